// File: rtl/branch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_ctrl_if
//  Description : Decoder/PC-side bundle for the branch controller. Carries
//                decoded branch ops, ALU flag writes, loop-counter loads and
//                the relative-branch request returned to the PC.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_ctrl_if #(
  parameter int W  = 8,
  parameter int LW = 8
);
  // Decoder / test-bench side
  logic          Start;
  logic          Going;
  logic [2:0]    BrOp;
  logic [W-1:0]  Offset;
  logic          FlagWr;
  logic          ZeroIn;
  logic          NegIn;
  logic          CarryIn;
  logic          LoopLd;
  logic [LW-1:0] LoopVal;

  // Branch controller side
  logic          BranchRelEn;
  logic [W-1:0]  Target;
  logic          forward;
  logic          Done;
  logic [LW-1:0] LoopCnt;

  // Driver of ops and flags (decoder or test bench)
  modport master (
    output Start, Going, BrOp, Offset, FlagWr, ZeroIn, NegIn, CarryIn,
           LoopLd, LoopVal,
    input  BranchRelEn, Target, forward, Done, LoopCnt
  );

  // The branch controller itself
  modport slave (
    input  Start, Going, BrOp, Offset, FlagWr, ZeroIn, NegIn, CarryIn,
           LoopLd, LoopVal,
    output BranchRelEn, Target, forward, Done, LoopCnt
  );
endinterface
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_ctrl
//  Description : Relative-branch request generator for the PC. Evaluates
//                decoded branch ops against registered ALU flags and a
//                hardware loop counter, converts the signed offset into a
//                magnitude/direction pair, and owns the sticky HALT/Done.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_ctrl #(
  parameter int W  = 8,
  parameter int LW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  branch_ctrl_if.slave  bus
);

  // Branch op encoding
  localparam logic [2:0] c_OP_NOP  = 3'b000;
  localparam logic [2:0] c_OP_BR   = 3'b001;
  localparam logic [2:0] c_OP_BZ   = 3'b010;
  localparam logic [2:0] c_OP_BNZ  = 3'b011;
  localparam logic [2:0] c_OP_BN   = 3'b100;
  localparam logic [2:0] c_OP_BC   = 3'b101;
  localparam logic [2:0] c_OP_DJNZ = 3'b110;
  localparam logic [2:0] c_OP_HALT = 3'b111;

  // Architectural state
  logic          r_zf;
  logic          r_nf;
  logic          r_cf;
  logic [LW-1:0] r_loop_cnt;
  logic          r_done;

  // Combinational helpers
  logic [W-1:0]  w_mag;
  logic          w_fwd;
  logic [LW-1:0] w_cnt_dec;
  logic          w_taken;
  logic          w_active;

  // State may only advance while the PC is ticking and the program is live
  assign w_active  = bus.Going & ~r_done;
  assign w_cnt_dec = r_loop_cnt - LW'(1);

  // Signed offset to magnitude/direction; -2^(W-1) maps to 2^(W-1) unsigned
  always_comb begin
    w_fwd = ~bus.Offset[W-1];
    w_mag = bus.Offset;
    if (bus.Offset[W-1]) begin
      w_mag = -bus.Offset;
    end
  end

  // Taken decision uses only pre-edge flags and counter, so a same-cycle
  // FlagWr or LoopLd never influences the branch it accompanies
  always_comb begin
    w_taken = 1'b0;
    case (bus.BrOp)
      c_OP_NOP:  w_taken = 1'b0;
      c_OP_BR:   w_taken = 1'b1;
      c_OP_BZ:   w_taken = r_zf;
      c_OP_BNZ:  w_taken = ~r_zf;
      c_OP_BN:   w_taken = r_nf;
      c_OP_BC:   w_taken = r_cf;
      c_OP_DJNZ: w_taken = (w_cnt_dec != '0);
      c_OP_HALT: w_taken = 1'b1;
      default:   w_taken = 1'b0;
    endcase
  end

  // Branch request to the PC; halted or halting programs branch to self
  always_comb begin
    bus.BranchRelEn = 1'b0;
    bus.Target      = '0;
    bus.forward     = 1'b1;
    if (r_done) begin
      bus.BranchRelEn = 1'b1;
    end else if (!bus.Going) begin
      bus.BranchRelEn = 1'b0;
    end else if (bus.BrOp == c_OP_HALT) begin
      bus.BranchRelEn = 1'b1;
    end else begin
      bus.BranchRelEn = w_taken;
      bus.Target      = w_mag;
      bus.forward     = w_fwd;
    end
  end

  assign bus.Done    = r_done;
  assign bus.LoopCnt = r_loop_cnt;

  // ALU flag register: captured only on an explicit write while live
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_zf <= 1'b0;
      r_nf <= 1'b0;
      r_cf <= 1'b0;
    end else if (w_active && bus.FlagWr) begin
      r_zf <= bus.ZeroIn;
      r_nf <= bus.NegIn;
      r_cf <= bus.CarryIn;
    end
  end

  // Hardware loop counter: a load beats the DJNZ decrement
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_loop_cnt <= '0;
    end else if (w_active) begin
      if (bus.LoopLd) begin
        r_loop_cnt <= bus.LoopVal;
      end else if (bus.BrOp == c_OP_DJNZ) begin
        r_loop_cnt <= w_cnt_dec;
      end
    end
  end

  // Sticky Done: set by HALT, cleared by Reset or a Start request
  always_ff @(posedge Clk) begin
    if (Reset || bus.Start) begin
      r_done <= 1'b0;
    end else if (w_active && (bus.BrOp == c_OP_HALT)) begin
      r_done <= 1'b1;
    end
  end

endmodule
`default_nettype wire
